// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready on both sides, 2-entry skid buffer, sync flush.
// Define PIPE_PERF_CNT_EN to add saturating stall_cnt / flush_cnt performance counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_valid) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_ctrl_q <= in_ctrl;
                            main_data_q <= in_data;
                        end else begin
                            main_ctrl_q <= '0;
                            main_data_q <= '0;
                            state_q     <= StEmpty;
                        end
                    end else if (in_valid) begin
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                        state_q     <= StFull;
                    end
                end
                StFull: begin
                    // in_ready is low here, so in_valid cannot be accepted.
                    if (out_ready) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        skid_ctrl_q <= '0;
                        skid_data_q <= '0;
                        state_q     <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        occupancy = state_q;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        out_data  = out_valid ? main_data_q : '0;
    end

    assert property (@(posedge clk) disable iff (rst)
        !(state_q == StFull && in_valid && in_ready && out_valid && out_ready));

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && state_q != StEmpty && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (e.g. MEM->WB).
- One generic, elastic pipeline stage register with a valid/ready handshake on both sides, a 2-entry skid buffer and a synchronous flush.
- The control field (write enables) is forced to zero whenever the stage holds a bubble, so a downstream stage never sees a stray write.
- Instantiated between any two CPU pipeline stages; replaces the per-stage stall-vector decode with local backpressure.

Parameters:
- DATA_W, 32: width of the payload field (wdata, hi, lo, addresses, packed by the instantiating stage).
- CTRL_W, 4: width of the control field (write-enable bits); zeroed on bubble, flush and reset.
- CNT_W, 16: width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (exception / ERET); discards all held entries.
- in_valid  input  1  upstream has a valid entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control/write-enable bits.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage presents a valid entry.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_ctrl  output  CTRL_W  control bits; 0 whenever out_valid=0.
- out_data  output  DATA_W  payload; 0 whenever out_valid=0.
- occupancy  output  2  number of held entries (0..2).
- stall_cnt  output  CNT_W  present only with PIPE_PERF_CNT_EN.
- flush_cnt  output  CNT_W  present only with PIPE_PERF_CNT_EN.

Behaviour:
- Storage: a main entry {main_ctrl, main_data} and a skid entry {skid_ctrl, skid_data}.
- State encoding: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid). occupancy reflects the current state.
- Handshake:
  - Upstream accept = in_valid & in_ready.
  - Downstream transfer = out_valid & out_ready.
  - in_ready = (state != FULL), decoded from registered state only. There is no combinational path from out_ready to in_ready.
  - out_valid = (state != EMPTY). out_ctrl/out_data = main entry when valid, else all-zero.
- Transitions (when no reset or flush):
  - EMPTY: in_valid -> main<=in, ONE. Otherwise stay in EMPTY.
  - ONE, out_ready & !in_valid -> EMPTY.
  - ONE, out_ready & in_valid -> main<=in, stay in ONE (full throughput, 1 entry/cycle).
  - ONE, !out_ready & in_valid -> skid<=in, FULL.
  - ONE, !out_ready & !in_valid -> hold.
  - FULL: out_ready -> main<=skid, ONE. Otherwise hold. in_valid is ignored because in_ready=0.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY. Ordering is strictly FIFO.
- Entries held while out_ready=0 keep ctrl and data stable; out_valid never drops without a transfer.
- rst (priority 1) or flush (priority 2): state<=EMPTY, both entries' ctrl and data <= 0.
  - An in_valid presented in the same cycle is dropped, not captured.
  - in_ready=1 from the next cycle.
- rst mid-stream behaves the same as flush. Counters are cleared only by rst.
- Simultaneous accept and transfer in FULL is impossible by construction; it is a verification assertion.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle with flush=1 and occupancy != 0.
  - Both counters saturate at all-ones and reset to 0 on rst only.
- Undefined: the counters and their ports are absent; there is no other behavioural difference.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_ctrl=4'hF -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 on the first cycle after release.
- Streaming: out_ready=1, push data 1..8 back-to-back with ctrl=4'h1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready held at 1.
- Backpressure: push A=0xAAAA0000 and B=0xBBBB0000 while out_ready=0 -> occupancy=2, in_ready=0, out_data=A held stable. Then raise out_ready -> A, then B, then out_valid=0 with out_ctrl=0.
- Flush while FULL: flush=1 with in_valid=1, data C -> next cycle occupancy=0 and out_valid=0; C never appears; in_ready=1.
- Bubble: in_valid=0 for 3 cycles between entries while in_ctrl=4'hF -> out_ctrl=0 during the gap.
- PIPE_PERF_CNT_EN with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Flush while EMPTY -> flush_cnt unchanged.
